// File: rtl/uncached_axi_bridge_pkg.sv
// uncached_axi_bridge_pkg: shared widths, FSM states and AXI size codes for the uncached bridge
package uncached_axi_bridge_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [3:0] RD_REQ = 4'b0000;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;
endpackage

// File: rtl/uncached_axi_bridge_if.sv
// uncached_axi_bridge_if: single-beat AXI4 read/write channels between the bridge and the system bus
interface uncached_axi_bridge_if;
    import uncached_axi_bridge_pkg::*;
    logic [ADDR_W-1:0] araddr;
    logic [2:0] arsize;
    logic arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic rvalid, rready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0] awsize;
    logic awvalid, awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0] wstrb;
    logic wvalid, wready;
    logic bvalid, bready;
    modport master (
        output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input arready, rdata, rvalid, awready, wready, bvalid
    );
    modport slave (
        input araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/uncached_axi_bridge_size_dec.sv
// uncached_axi_bridge_size_dec: write strobes to AXI transfer size and low address bits
module uncached_axi_bridge_size_dec
    import uncached_axi_bridge_pkg::*;
(
    input  logic [3:0] byte_en,
    output logic [2:0] size,
    output logic [1:0] offset
);
    always_comb begin
        size = SIZE_W;
        offset = 2'd0;
        case (byte_en)
            4'b0001: size = SIZE_B;
            4'b0010: begin size = SIZE_B; offset = 2'd1; end
            4'b0100: begin size = SIZE_B; offset = 2'd2; end
            4'b1000: begin size = SIZE_B; offset = 2'd3; end
            4'b0011: size = SIZE_H;
            4'b1100: begin size = SIZE_H; offset = 2'd2; end
            default: ;
        endcase
    end
endmodule

// File: rtl/uncached_axi_bridge.sv
// uncached_axi_bridge: turns one uncached CPU request into one single-beat AXI4 read or write
module uncached_axi_bridge
    import uncached_axi_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic [3:0] byte_en_i,
    input  logic [ADDR_W-1:0] rw_addr_i,
    input  logic [DATA_W-1:0] write_data_i,
    output logic ready_o,
    output logic [DATA_W-1:0] read_data_o,
    uncached_axi_bridge_if.master bus
);
    state_t state, nxt;
    logic [ADDR_W-1:2] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0] strb_q;
    logic aw_done, w_done, guard;
    logic [2:0] wr_size;
    logic [1:0] wr_off;
    logic aw_fin, w_fin;

    uncached_axi_bridge_size_dec u_dec (.byte_en(strb_q), .size(wr_size), .offset(wr_off));

    assign aw_fin = aw_done | (bus.awvalid & bus.awready);
    assign w_fin = w_done | (bus.wvalid & bus.wready);

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = (en_i && !guard) ? ((byte_en_i == RD_REQ) ? RD_ADDR : WR) : IDLE;
            RD_ADDR: nxt = bus.arready ? RD_DATA : RD_ADDR;
            RD_DATA: nxt = bus.rvalid ? DONE : RD_DATA;
            WR: nxt = (aw_fin && w_fin) ? WR_RESP : WR;
            WR_RESP: nxt = bus.bvalid ? DONE : WR_RESP;
            default: nxt = IDLE;
        endcase
    end

    // guard blocks the still-high en_i seen in the cycle after DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            guard <= 1'b0;
            read_data_o <= '0;
        end else begin
            state <= nxt;
            guard <= state == DONE;
            aw_done <= state == WR && nxt == WR && aw_fin;
            w_done <= state == WR && nxt == WR && w_fin;
            if (state == IDLE && nxt != IDLE) begin
                addr_q <= rw_addr_i[ADDR_W-1:2];
                data_q <= write_data_i;
                strb_q <= byte_en_i;
            end
            if (state == RD_DATA && bus.rvalid) read_data_o <= bus.rdata;
        end
    end

    assign bus.arvalid = state == RD_ADDR;
    assign bus.araddr = {addr_q, 2'b00};
    assign bus.arsize = SIZE_W;
    assign bus.rready = state == RD_DATA;
    assign bus.awvalid = state == WR && !aw_done;
    assign bus.wvalid = state == WR && !w_done;
    assign bus.awaddr = {addr_q, wr_off};
    assign bus.awsize = wr_size;
    assign bus.wdata = data_q;
    assign bus.wstrb = strb_q;
    assign bus.bready = state == WR_RESP;
    assign ready_o = state == DONE;
endmodule

// File: doc/uncached_axi_bridge.md
Name: uncached_axi_bridge

Overview:
- Responder for the MMU's uncached request channel (`uncached_en_o`, `byte_en`, `rw_addr`, `write_data` in; `ready` and `read_data` back to the CPU).
- Converts each request into exactly one single-beat AXI4 read or write on the system bus. Burst length is 0, burst type is INCR, and ID is 0; these are tied off in the interconnect wrapper.
- Serves MMIO and other uncached regions. One transaction is outstanding at a time, and the CPU stalls until `ready_o`.

Parameters:
- None. Widths come from `ADDR_BUS` and `DATA_BUS` in bus.v (32 bits each).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en_i  in  1  request valid; held high until the ready_o cycle
- byte_en_i  in  4  4'b0000 = read; nonzero = write strobes
- rw_addr_i  in  32  byte address
- write_data_i  in  32  write data, lane-aligned
- ready_o  out  1  one-cycle completion pulse
- read_data_o  out  32  read result, valid while ready_o is high, held afterwards
- araddr  out  32  AXI read address
- arsize  out  3  AXI read size
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- rdata  in  32  AXI read data
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- awaddr  out  32  AXI write address
- awsize  out  3  AXI write size
- awvalid  out  1  AXI write address valid
- awready  in  1  AXI write address ready
- wdata  out  32  AXI write data
- wstrb  out  4  AXI write strobes
- wvalid  out  1  AXI write data valid
- wready  in  1  AXI write data ready
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every valid/ready output 0; ready_o 0; address/data/strobe registers and read_data_o 0.
- Reset mid-transaction abandons the transaction; no further bus handshakes are issued.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE: when en_i=1, latch address, data and strobes.
  - byte_en_i==0 → RD_ADDR.
  - otherwise → WR.
- RD_ADDR: arvalid=1, araddr={rw_addr[31:2],2'b00}, arsize=3'd2. On arready → RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata into read_data_o → DONE.
- WR: awvalid and wvalid both assert on entry and are tracked independently with aw_done and w_done flags.
  - Each valid drops the cycle after its own handshake.
  - When both handshakes are done (same cycle or different cycles) → WR_RESP.
  - wdata=write_data, wstrb=byte_en.
- awsize/awaddr[1:0] decode from strobes:
  - single-lane 0001/0010/0100/1000 → size 0, offset 0/1/2/3
  - 0011 → size 1, offset 0
  - 1100 → size 1, offset 2
  - anything else → size 2, offset 0
- WR_RESP: bready=1. On bvalid → DONE. bresp is ignored.
- DONE: ready_o=1 for exactly this cycle, then → IDLE.
  - IDLE does not accept en_i in the cycle right after DONE: a one-cycle guard flag blocks it, because the CPU drops en_i only after seeing ready_o.
- AXI rules:
  - A valid, once raised, stays high with stable payload until the handshake completes.
  - No valid depends combinationally on the matching ready.
- Minimum latency, read: en_i at cycle 0 → arvalid at 1 → (arready at 1) rready at 2 → (rvalid at 2) ready_o at 3.
- Minimum latency, write: AW/W at 1 → bready at 2 → ready_o at 3.
- Requests never overlap, so there is no queueing and no full/empty condition.

Decomposition:
- Shared header uncached_def.v holds:
  - the state encodings (3-bit localparams),
  - AXI size constants SIZE_B=3'd0, SIZE_H=3'd1, SIZE_W=3'd2,
  - the read-request encoding 4'b0000.
- One combinational sub-module, uncached_size_dec: byte_en[3:0] → {size[2:0], offset[1:0]}. It is tested standalone over all 16 inputs.

Test Plan:
- Read, zero wait: en_i=1, addr=0x1FD0_F002, byte_en=0; arready and rvalid tied 1, rdata=0xDEAD_BEEF → araddr=0x1FD0_F000, arsize=2, ready_o at cycle 3, read_data_o=0xDEAD_BEEF.
- Byte write with backpressure: byte_en=0100, addr=0x1FD0_0000, data=0x00AB_0000; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 3 cycles with stable awaddr=0x1FD0_0002, awsize=0; single ready_o after bvalid.
- Halfword write, W before AW: byte_en=1100, wready at cycle 1, awready at cycle 4 → WR_RESP only after cycle 4, awsize=1, awaddr offset 2.
- Held en_i: keep en_i=1 for two cycles after ready_o → no second arvalid in the guard cycle. A new request is issued only if en_i is still high two cycles after DONE.
- Reset mid-read: assert rst low while in RD_DATA → all outputs 0 immediately (asynchronously); after release, state IDLE and no spurious ready_o.
- Strobe decode sweep: all 16 byte_en values through uncached_size_dec → sizes and offsets match the table in Behaviour.
